// File: rtl/idma_axis_ep_pkg.sv
// Shared types and helpers for the iDMA AXI-Stream loopback endpoint.
package idma_axis_ep_pkg;

    // Widest strobe vector the popcount helper accepts (DataWidth up to 1024).
    localparam int unsigned MaxStrbWidth = 128;

    typedef logic [MaxStrbWidth-1:0] strb_vec_t;

    // Default AXI-Stream channel types for a 64-bit stream.
    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic [7:0]  keep;
        logic        last;
        logic [3:0]  id;
        logic [3:0]  dest;
        logic [3:0]  user;
    } ep_axis_t_chan_t;

    typedef struct packed {
        ep_axis_t_chan_t t;
        logic            tvalid;
    } ep_axis_req_t;

    typedef struct packed {
        logic tready;
    } ep_axis_rsp_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FORCED = 2'd2
    } src_state_e;

    // Number of set bits in a (zero-extended) strobe vector.
    function automatic logic [7:0] popcount(input strb_vec_t bits);
        logic [7:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < MaxStrbWidth; i++) begin
            cnt = cnt + 8'(bits[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/idma_axis_ep_fifo.sv
// Circular beat buffer with wrap-bit pointers; head is read combinationally,
// a written entry becomes visible only after the write edge (no fall-through).
module idma_axis_ep_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [Width-1:0]         wdata,
    input  logic                     pop,
    output logic [Width-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   usage
);
    localparam int unsigned AddrWidth = $clog2(Depth);

    typedef logic [AddrWidth:0] ptr_t;

    logic [Width-1:0] mem [Depth];
    ptr_t             wr_ptr;
    ptr_t             rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer update; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ptr_t'(1);
            if (do_pop)  rd_ptr <= rd_ptr + ptr_t'(1);
        end
    end

    // Storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AddrWidth-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AddrWidth-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AddrWidth] != rd_ptr[AddrWidth]) &&
                   (wr_ptr[AddrWidth-1:0] == rd_ptr[AddrWidth-1:0]);
    assign usage = wr_ptr - rd_ptr;

endmodule

// File: rtl/idma_axis_loopback_endpoint.sv
// AXI-Stream loopback endpoint: buffers the iDMA write stream and replays it
// on the read stream, store-and-forward or cut-through, with statistics.
module idma_axis_loopback_endpoint
    import idma_axis_ep_pkg::*;
#(
    parameter int unsigned DataWidth       = 64,
    parameter int unsigned Depth           = 16,
    parameter logic        StoreAndForward = 1'b1,
    parameter int unsigned CntWidth        = 32,
    parameter type         axis_req_t      = ep_axis_req_t,
    parameter type         axis_rsp_t      = ep_axis_rsp_t
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  axis_req_t               axis_sink_req_i,
    output axis_rsp_t               axis_sink_rsp_o,
    output axis_req_t               axis_src_req_o,
    input  axis_rsp_t               axis_src_rsp_i,
    input  logic                    clear_i,
    output logic [$clog2(Depth):0]  fill_o,
    output logic [CntWidth-1:0]     rx_bytes_o,
    output logic [CntWidth-1:0]     rx_pkts_o,
    output logic [CntWidth-1:0]     tx_pkts_o,
    output logic                    oversize_o
);
    localparam int unsigned StrbWidth  = DataWidth / 8;
    localparam int unsigned EntryWidth = DataWidth + 2 * StrbWidth + 1;
    localparam int unsigned PktWidth   = $clog2(Depth) + 1;

    typedef logic [PktWidth-1:0] pkt_cnt_t;
    typedef logic [CntWidth-1:0] cnt_t;

    src_state_e             state_q;
    src_state_e             state_d;
    pkt_cnt_t               pkt_cnt_q;
    logic                   full;
    logic                   empty;
    logic [EntryWidth-1:0]  wdata;
    logic [EntryWidth-1:0]  rdata;
    logic                   sink_ready;
    logic                   push;
    logic                   push_last;
    logic                   src_valid;
    logic                   pop;
    logic                   pop_last;
    logic                   force_entry;
    logic [DataWidth-1:0]   head_data;
    logic [StrbWidth-1:0]   head_strb;
    logic [StrbWidth-1:0]   head_keep;
    logic                   head_last;
    cnt_t                   beat_bytes;
    logic                   unused_sink_side;

    assign sink_ready = !full && !rst_i;
    assign push       = axis_sink_req_i.tvalid && sink_ready;
    assign push_last  = push && axis_sink_req_i.t.last;
    assign pop        = src_valid && axis_src_rsp_i.tready;
    assign pop_last   = pop && head_last;

    assign wdata = {axis_sink_req_i.t.data, axis_sink_req_i.t.strb,
                    axis_sink_req_i.t.keep, axis_sink_req_i.t.last};

    assign head_data = rdata[EntryWidth-1 -: DataWidth];
    assign head_strb = rdata[2*StrbWidth -: StrbWidth];
    assign head_keep = rdata[StrbWidth -: StrbWidth];
    assign head_last = rdata[0];

    assign beat_bytes = cnt_t'(popcount(strb_vec_t'(axis_sink_req_i.t.strb &
                                                    axis_sink_req_i.t.keep)));

    assign unused_sink_side = ^{axis_sink_req_i.t.id, axis_sink_req_i.t.dest,
                                axis_sink_req_i.t.user};

    idma_axis_ep_fifo #(
        .Width (EntryWidth),
        .Depth (Depth)
    ) i_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .usage (fill_o)
    );

    // Source state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Source next-state and valid. IDLE looks at the same-cycle push so a
    // just-accepted beat (or packet end) is offered one cycle after acceptance.
    always_comb begin
        state_d     = state_q;
        src_valid   = 1'b0;
        force_entry = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (StoreAndForward) begin
                    if (pkt_cnt_q != '0 || push_last) begin
                        state_d = STREAM;
                    end else if (full) begin
                        state_d     = FORCED;
                        force_entry = 1'b1;
                    end
                end else if (!empty || push) begin
                    state_d = STREAM;
                end
            end
            STREAM, FORCED: begin
                src_valid = !empty && !rst_i;
                if (src_valid && axis_src_rsp_i.tready && head_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Count of complete packets held in the buffer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pkt_cnt_q <= '0;
        end else if (push_last && !pop_last) begin
            pkt_cnt_q <= pkt_cnt_q + pkt_cnt_t'(1);
        end else if (!push_last && pop_last) begin
            pkt_cnt_q <= pkt_cnt_q - pkt_cnt_t'(1);
        end
    end

    // Statistics and sticky oversize flag; clear wins over a same-cycle update.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            rx_bytes_o <= '0;
            rx_pkts_o  <= '0;
            tx_pkts_o  <= '0;
            oversize_o <= 1'b0;
        end else begin
            if (push)        rx_bytes_o <= rx_bytes_o + beat_bytes;
            if (push_last)   rx_pkts_o  <= rx_pkts_o + cnt_t'(1);
            if (pop_last)    tx_pkts_o  <= tx_pkts_o + cnt_t'(1);
            if (force_entry) oversize_o <= 1'b1;
        end
    end

    // Port assembly; sideband fields of the replayed stream are zero.
    always_comb begin
        axis_src_req_o        = '0;
        axis_src_req_o.tvalid = src_valid;
        axis_src_req_o.t.data = head_data;
        axis_src_req_o.t.strb = head_strb;
        axis_src_req_o.t.keep = head_keep;
        axis_src_req_o.t.last = head_last;
    end

    always_comb begin
        axis_sink_rsp_o        = '0;
        axis_sink_rsp_o.tready = sink_ready;
    end

endmodule
